veda_regfile_mp: RTL and testbench
==================================

# veda_regfile_mp

Parametrised multi-read-port register file with per-port scribble/interpret modes, write-first bypass, a registered two-stage read pipeline, and a sequenced soft-clear engine. It is the general-width/depth/port successor of the team's single-port 32x32 scribble/interpret store. It sits between the datapath write-back stage and the consumers that need either stored values or a pass-through of the current write data.

## Interface
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (1..8)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears every entry, pipeline, and FSM
- wr_valid  input  1  write request
- wr_ready  output  1  write accept; write occurs when wr_valid && wr_ready
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- rd_en  input  NUM_RD  per-port read request
- rd_mode  input  NUM_RD  per-port mode: 0 = scribble (return wr_data), 1 = interpret (return memory)
- rd_addr  input  NUM_RD*ADDR_W  per-port address, port p at bits [p*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  per-port result, same packing
- rd_valid  output  NUM_RD  per-port result valid
- clr_req  input  1  soft-clear request, single-cycle pulse
- busy  output  1  high while the clear sequence runs

## Operation
- FSM states are IDLE and CLEAR. The reset state is IDLE.
- In IDLE, wr_ready is 1. An accepted write stores wr_data at wr_addr.
- IDLE -> CLEAR on clr_req. The clear counter loads 0.
- In CLEAR, the block writes zero to entry[counter] each cycle and increments the counter.
  - wr_ready is 0 and busy is 1.
  - After writing entry DEPTH-1, the FSM returns to IDLE, so the sequence takes exactly DEPTH cycles.
- clr_req is ignored while in CLEAR.
- If clr_req and an accepted write occur in the same IDLE cycle, the write commits first and the clear starts next cycle, so the written entry ends at 0.
- Read stage 1, in the cycle where rd_en[p] is 1:
  - In scribble mode, the port captures wr_data unconditionally, regardless of wr_valid.
  - In interpret mode, the port captures entry[rd_addr[p]] with write-first bypass. If a write or clear-zero targets the same address in that cycle, the new value (wr_data or 0) is captured.
- Read stage 2: the stage-1 register moves to rd_data[p], and rd_valid[p] = delayed rd_en[p].
- When rd_en[p] is 0, rd_data[p] holds its last value and rd_valid[p] is 0.
- Reads are allowed in all FSM states, including CLEAR, and are never stalled.
- Ports are fully independent; any number of ports may read the same address.
- Reset values: all entries 0, rd_data 0, rd_valid 0, busy 0, wr_ready 1, FSM IDLE, counter 0.
- Reset asserted mid-clear aborts the sequence immediately. All entries are 0 on release.

## Timing
- Read latency is 2 cycles: rd_en sampled at edge N gives rd_data/rd_valid valid after edge N+1.
- Throughput is one read per port per cycle, fully pipelined.
- Write latency is 1 cycle. An interpret read issued in the cycle after the write edge sees the new data from the array; a same-cycle read sees it via the bypass.
- busy rises the edge after clr_req and falls at the edge that writes entry DEPTH-1.
- wr_ready = !busy, driven combinationally from the FSM register (no input dependence).

## Structure
- The shared package veda_pkg holds:
  - mode constants MODE_SCRIBBLE = 1'b0 and MODE_INTERPRET = 1'b1;
  - the FSM state enum (ST_IDLE, ST_CLEAR).
- One sub-module, veda_rd_port, contains the per-port two-stage pipeline and mode mux. It is instantiated NUM_RD times via generate.
- The array, bypass compare, and clear FSM live in the top module.

## Test plan
- Reset, then write 0xDEADBEEF to addr 3; port0 interpret read addr 3 the next cycle -> rd_data0 = 0xDEADBEEF two cycles later with rd_valid0 = 1.
- Same-cycle write 0x12345678 to addr 7 plus port1 interpret read addr 7 -> rd_data1 = 0x12345678 (bypass); port0 scribble in the same cycle -> rd_data0 = 0x12345678.
- Fill all entries with value = address; pulse clr_req:
  - busy is high for exactly DEPTH (32) cycles and wr_valid is refused;
  - afterwards, reading every address returns 0.
- Issue clr_req with a simultaneous write 0xAAAA0000 to addr 0 -> entry 0 reads 0 after the clear.
- Assert reset at clear cycle 10 with entries 20..31 still nonzero -> busy = 0, rd_valid = 0, and all entries read 0 after release.
- NUM_RD = 4, DATA_W = 16, ADDR_W = 3 build: all four ports read distinct addresses back-to-back every cycle -> correct data each cycle, with no bubbles.

Source files
------------

// File: rtl/veda_pkg.sv
// Shared definitions for the veda register file.
//   MODE_SCRIBBLE / MODE_INTERPRET : per-port read mode encodings
//   veda_state_e                   : clear-engine FSM states
package veda_pkg;

  localparam logic MODE_SCRIBBLE  = 1'b0;  // return current wr_data
  localparam logic MODE_INTERPRET = 1'b1;  // return stored entry

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_CLEAR
  } veda_state_e;

endpackage

// File: rtl/veda_rd_port.sv
// One read port: mode mux into a stage-1 register, then a stage-2 output register.
//   clk, reset : clock, async active-high reset
//   rd_en      : read request (sampled into stage 1)
//   rd_mode    : MODE_SCRIBBLE selects wr_data, MODE_INTERPRET selects mem_data
//   mem_data   : stored entry, already bypassed with any same-cycle write
//   wr_data    : raw write-data bus
//   rd_data    : result, held when no new read completes
//   rd_valid   : result valid, two cycles after rd_en
module veda_rd_port
  import veda_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              rd_mode,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  always_comb begin
    s1_data_d   = s1_data_q;
    s1_valid_d  = rd_en;
    out_data_d  = out_data_q;
    out_valid_d = s1_valid_q;
    if (rd_en) begin
      s1_data_d = (rd_mode == MODE_INTERPRET) ? mem_data : wr_data;
    end
    // Output only advances on a completed read so it holds otherwise.
    if (s1_valid_q) begin
      out_data_d = s1_data_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data_q   <= '0;
      s1_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_data_q   <= s1_data_d;
      s1_valid_q  <= s1_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rd_data  = out_data_q;
  assign rd_valid = out_valid_q;

endmodule

// File: rtl/veda_regfile_mp.sv
// Multi-read-port register file with scribble/interpret read modes, write-first
// bypass, two-stage read pipeline and a sequenced soft-clear engine.
//   clk, reset                 : clock, async active-high reset (clears everything)
//   wr_valid/wr_ready          : write handshake; wr_ready low while clearing
//   wr_addr, wr_data           : write address / data
//   rd_en, rd_mode, rd_addr    : per-port read request, mode, packed addresses
//   rd_data, rd_valid          : per-port packed results, 2-cycle latency
//   clr_req                    : start zeroing all entries, one per cycle
//   busy                       : clear sequence in progress
module veda_regfile_mp
  import veda_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD-1:0]        rd_mode,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic                     clr_req,
  output logic                     busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  veda_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Effective array write: either an accepted host write or a clear-zero.
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  assign busy     = (state_q == ST_CLEAR);
  assign wr_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we      = 1'b0;
    waddr   = wr_addr;
    wdata   = wr_data;
    unique case (state_q)
      ST_IDLE: begin
        we = wr_valid;
        // A same-cycle write still commits; the clear then overwrites it.
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = '0;
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] byp_data;

    assign addr     = rd_addr[p*ADDR_W +: ADDR_W];
    // Write-first: a same-cycle write/clear to this address wins over the array.
    assign byp_data = (we && (waddr == addr)) ? wdata : mem_q[addr];

    veda_rd_port #(
      .DATA_W(DATA_W)
    ) u_rd_port (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (rd_en[p]),
      .rd_mode (rd_mode[p]),
      .mem_data(byp_data),
      .wr_data (wr_data),
      .rd_data (rd_data[p*DATA_W +: DATA_W]),
      .rd_valid(rd_valid[p])
    );
  end

endmodule

// File: tb/tb_veda_regfile_mp.sv
module tb_veda_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NR-1:0] rd_en;
  logic [NR-1:0] rd_mode;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0] rd_valid;
  logic          clr_req;
  logic          busy;

  // Second build: 4 ports, 16-bit data, 8 entries.
  logic          b_wr_valid;
  logic          b_wr_ready;
  logic [2:0]    b_wr_addr;
  logic [15:0]   b_wr_data;
  logic [3:0]    b_rd_en;
  logic [3:0]    b_rd_mode;
  logic [11:0]   b_rd_addr;
  logic [63:0]   b_rd_data;
  logic [3:0]    b_rd_valid;
  logic          b_clr_req;
  logic          b_busy;

  always #5 clk = ~clk;

  veda_regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_mode (rd_mode),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .clr_req (clr_req),
    .busy    (busy)
  );

  veda_regfile_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .wr_valid(b_wr_valid),
    .wr_ready(b_wr_ready),
    .wr_addr (b_wr_addr),
    .wr_data (b_wr_data),
    .rd_en   (b_rd_en),
    .rd_mode (b_rd_mode),
    .rd_addr (b_rd_addr),
    .rd_data (b_rd_data),
    .rd_valid(b_rd_valid),
    .clr_req (b_clr_req),
    .busy    (b_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy;
  int            m_cnt;
  logic [DW-1:0] e_prev [NR];
  bit            v_prev [NR];
  logic [DW-1:0] hold   [NR];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_busy = 0;
    m_cnt  = 0;
    for (int p = 0; p < NR; p++) begin
      e_prev[p] = '0;
      v_prev[p] = 0;
      hold[p]   = '0;
    end
  endtask

  task automatic idle_inputs();
    wr_valid = 0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_mode = '0; rd_addr = '0; clr_req = 0;
  endtask

  task automatic set_rd(input int p, input bit en, input bit mode, input int addr);
    rd_en[p]   = en;
    rd_mode[p] = mode;
    rd_addr[p*AW +: AW] = AW'(addr);
  endtask

  // One clock: predict results from current inputs, clock, update model, check.
  task automatic step();
    logic [DW-1:0] e_cur [NR];
    bit            v_cur [NR];
    bit            wacc;
    int            a;
    wacc = wr_valid && !m_busy;
    for (int p = 0; p < NR; p++) begin
      a = int'(rd_addr[p*AW +: AW]);
      v_cur[p] = rd_en[p];
      if (rd_mode[p] == 1'b0)            e_cur[p] = wr_data;
      else if (m_busy && m_cnt == a)     e_cur[p] = '0;
      else if (wacc && int'(wr_addr) == a) e_cur[p] = wr_data;
      else                               e_cur[p] = m_mem[a];
    end
    @(posedge clk);
    if (m_busy) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == DEPTH - 1) m_busy = 0;
      m_cnt = (m_cnt + 1) % DEPTH;
    end else begin
      if (wr_valid) m_mem[wr_addr] = wr_data;
      if (clr_req) begin
        m_busy = 1;
        m_cnt  = 0;
      end
    end
    #1;
    chk("busy", 32'(busy), 32'(m_busy));
    chk("wr_ready", 32'(wr_ready), 32'(!m_busy));
    for (int p = 0; p < NR; p++) begin
      if (v_prev[p]) hold[p] = e_prev[p];
      chk($sformatf("rd_valid%0d", p), 32'(rd_valid[p]), 32'(v_prev[p]));
      chk($sformatf("rd_data%0d", p), rd_data[p*DW +: DW], hold[p]);
      e_prev[p] = e_cur[p];
      v_prev[p] = v_cur[p];
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data0"}, rd_data[0 +: DW], 32'd0);
    chk({tag, "_rd_data1"}, rd_data[DW +: DW], 32'd0);
  endtask

  task automatic read_all();
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, 1, 1, a);
      set_rd(1, 1, 1, DEPTH - 1 - a);
      step();
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic fill(input int base);
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      wr_valid = 1; wr_addr = AW'(a); wr_data = DW'(a + base);
      step();
    end
    idle_inputs();
  endtask

  initial begin
    int busy_cnt;
    idle_inputs();
    b_wr_valid = 0; b_wr_addr = '0; b_wr_data = '0;
    b_rd_en = '0; b_rd_mode = '0; b_rd_addr = '0; b_clr_req = 0;
    model_reset();
    reset = 1;
    #12;
    reset_checks("reset");
    chk("reset_b_wr_ready", 32'(b_wr_ready), 32'd1);
    @(negedge clk);
    reset = 0;

    // Write then read next cycle.
    wr_valid = 1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    set_rd(0, 1, 1, 3);
    step();
    idle_inputs();
    step();
    chk("t1_data0", rd_data[0 +: DW], 32'hDEADBEEF);
    chk("t1_valid0", 32'(rd_valid[0]), 32'd1);

    // Same-cycle write with bypass read (port1) and scribble (port0).
    wr_valid = 1; wr_addr = 5'd7; wr_data = 32'h12345678;
    set_rd(1, 1, 1, 7);
    set_rd(0, 1, 0, 20);
    step();
    idle_inputs();
    step();
    chk("t2_bypass1", rd_data[DW +: DW], 32'h12345678);
    chk("t2_scribble0", rd_data[0 +: DW], 32'h12345678);
    step();
    chk("t2_valid_drop", 32'(rd_valid), 32'd0);
    chk("t2_hold1", rd_data[DW +: DW], 32'h12345678);

    // Full clear: busy for exactly DEPTH cycles, writes refused.
    fill(0);
    read_all();
    clr_req = 1;
    step();
    busy_cnt = int'(busy);
    clr_req = 0;
    for (int i = 0; i < DEPTH + 8; i++) begin
      wr_valid = (i < DEPTH);
      wr_addr  = AW'($urandom);
      wr_data  = $urandom | 32'h1;
      clr_req  = (i == 5);
      set_rd(0, 1, 1, int'($urandom_range(0, DEPTH - 1)));
      step();
      busy_cnt += int'(busy);
    end
    chk("t3_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    read_all();
    chk("t3_last_read0", rd_data[0 +: DW], 32'd0);

    // clr_req with a simultaneous write to entry 0.
    clr_req = 1; wr_valid = 1; wr_addr = '0; wr_data = 32'hAAAA0000;
    step();
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) step();
    set_rd(0, 1, 1, 0);
    step();
    idle_inputs();
    step();
    chk("t4_entry0", rd_data[0 +: DW], 32'd0);
    chk("t4_valid0", 32'(rd_valid[0]), 32'd1);

    // Reset mid-clear.
    fill(100);
    clr_req = 1;
    step();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      set_rd(1, 1, 1, 25);
      step();
    end
    chk("t5_entry25_live", rd_data[DW +: DW], 32'd125);
    #2;
    reset = 1;
    #1;
    reset_checks("midclr");
    model_reset();
    @(negedge clk);
    reset = 0;
    idle_inputs();
    read_all();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      wr_valid = 1'($urandom);
      wr_addr  = AW'($urandom);
      wr_data  = $urandom;
      clr_req  = ($urandom_range(0, 59) == 0);
      for (int p = 0; p < NR; p++) begin
        set_rd(p, 1'($urandom), 1'($urandom), int'($urandom_range(0, DEPTH - 1)));
      end
      step();
    end
    idle_inputs();
    step();
    step();

    // Four-port build: fill, then back-to-back distinct-address reads.
    for (int a = 0; a < 8; a++) begin
      b_wr_valid = 1; b_wr_addr = 3'(a); b_wr_data = 16'(16'hA000 + a * 3);
      @(posedge clk); #1;
    end
    b_wr_valid = 0;
    for (int c = 0; c < 10; c++) begin
      for (int p = 0; p < 4; p++) begin
        b_rd_en[p]   = (c < 8);
        b_rd_mode[p] = 1'b1;
        b_rd_addr[p*3 +: 3] = 3'((c + p * 2) % 8);
      end
      @(posedge clk); #1;
      if (c >= 1) begin
        for (int p = 0; p < 4; p++) begin
          if (c - 1 < 8) begin
            chk($sformatf("b_valid%0d_c%0d", p, c), 32'(b_rd_valid[p]), 32'd1);
            chk($sformatf("b_data%0d_c%0d", p, c), 32'(b_rd_data[p*16 +: 16]),
                32'(16'hA000 + ((c - 1 + p * 2) % 8) * 3));
          end else begin
            chk($sformatf("b_valid%0d_c%0d", p, c), 32'(b_rd_valid[p]), 32'd0);
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
